// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: req/ack data-memory bus between the load/store unit (master)
// and the data memory (slave).
interface dmem_lsu_if #(
    parameter int unsigned AWIDTH = 32
);
    logic              req;
    logic              we;
    logic [AWIDTH-1:0] addr;
    logic [3:0]        be;
    logic [AWIDTH-1:0] wdata;
    logic              ack;
    logic              err;
    logic [AWIDTH-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, err, rdata);
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I memory-stage load/store unit; stalls the pipeline while a bus access is open.
// Optional macro DMEM_MISALIGN_TRAP_EN faults misaligned H/W accesses without a bus cycle.
module dmem_lsu #(
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemEn,
    input  logic              MemRW,
    input  logic [2:0]        ILoad,
    input  logic [AWIDTH-1:0] Addr,
    input  logic [AWIDTH-1:0] WData,
    output logic [AWIDTH-1:0] RData,
    output logic              Stall_M,
    output logic              Fault,
    dmem_lsu_if.master        bus
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;

    logic [3:0]        be_c;
    logic [AWIDTH-1:0] wdata_c;
    logic [AWIDTH-1:0] load_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic              trap_c;

    assign Stall_M = ((state == IDLE) && MemEn) || (state == ACCESS);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap_c = ((ILoad[1:0] == 2'b01) && Addr[0]) ||
                    ((ILoad[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
`else
    assign trap_c = 1'b0;
`endif

    // Request lanes derived from the incoming instruction
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = WData;
        case (ILoad[1:0])
            2'b00: begin
                be_c    = 4'b0001 << Addr[1:0];
                wdata_c = {4{WData[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {Addr[1], 1'b0};
                wdata_c = {2{WData[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select and extension of the returned word using the captured offset
    always_comb begin
        byte_c = bus.rdata[7:0];
        case (off_q)
            2'd1:    byte_c = bus.rdata[15:8];
            2'd2:    byte_c = bus.rdata[23:16];
            2'd3:    byte_c = bus.rdata[31:24];
            default: ;
        endcase
        half_c = off_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
        case (size_q)
            2'b00:   load_c = uns_q ? {{(AWIDTH-8){1'b0}}, byte_c}
                                    : {{(AWIDTH-8){byte_c[7]}}, byte_c};
            2'b01:   load_c = uns_q ? {{(AWIDTH-16){1'b0}}, half_c}
                                    : {{(AWIDTH-16){half_c[15]}}, half_c};
            default: load_c = bus.rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            off_q     <= 2'b00;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.be    <= 4'b0000;
            bus.wdata <= '0;
            RData     <= '0;
            Fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemEn) begin
                        size_q <= ILoad[1:0];
                        uns_q  <= ILoad[2];
                        off_q  <= Addr[1:0];
                        cnt    <= '0;
                        if (trap_c) begin
                            state <= DONE;
                            Fault <= 1'b1;
                            RData <= '0;
                        end else begin
                            state     <= ACCESS;
                            bus.req   <= 1'b1;
                            bus.we    <= MemRW;
                            bus.addr  <= {Addr[AWIDTH-1:2], 2'b00};
                            bus.be    <= be_c;
                            bus.wdata <= wdata_c;
                        end
                    end
                end
                ACCESS: begin
                    // ack takes priority over a simultaneous timeout
                    if (bus.ack) begin
                        state   <= DONE;
                        bus.req <= 1'b0;
                        Fault   <= bus.err;
                        RData   <= bus.err ? '0 : load_c;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        bus.req <= 1'b0;
                        Fault   <= 1'b1;
                        RData   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed self-checking bench for dmem_lsu acting as the data-memory responder.
module tb_dmem_lsu;

    logic        clk;
    logic        rst_n;
    logic        MemEn;
    logic        MemRW;
    logic [2:0]  ILoad;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        Stall_M;
    logic        Fault;

    int checks = 0;
    int errors = 0;

    int          stalls;
    int          reqs;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    dmem_lsu_if #(.AWIDTH(32)) bus_if ();

    dmem_lsu #(.AWIDTH(32), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .MemEn   (MemEn),
        .MemRW   (MemRW),
        .ILoad   (ILoad),
        .Addr    (Addr),
        .WData   (WData),
        .RData   (RData),
        .Stall_M (Stall_M),
        .Fault   (Fault),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction and act as memory; ack after 'delay' ACCESS cycles (<0: never).
    // Returns in the first non-stall cycle (DONE) or after a bounded number of cycles.
    task automatic run_op(input logic rw, input logic [2:0] ld, input logic [31:0] a,
                          input logic [31:0] wd, input int delay, input logic [31:0] rd,
                          input logic e);
        MemEn  = 1'b1;
        MemRW  = rw;
        ILoad  = ld;
        Addr   = a;
        WData  = wd;
        stalls = 0;
        reqs   = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (Stall_M) stalls++;
            if (bus_if.req) begin
                reqs++;
                if (reqs == 1) begin
                    cap_we    = bus_if.we;
                    cap_addr  = bus_if.addr;
                    cap_be    = bus_if.be;
                    cap_wdata = bus_if.wdata;
                end
            end
            if (bus_if.req && (delay >= 0) && (reqs == delay + 1)) begin
                bus_if.ack   = 1'b1;
                bus_if.err   = e;
                bus_if.rdata = rd;
            end else begin
                bus_if.ack   = 1'b0;
                bus_if.err   = 1'b0;
                bus_if.rdata = 32'h0;
            end
            if (!Stall_M) break;
            @(negedge clk);
        end
    endtask

    task automatic finish_op();
        MemEn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        MemEn        = 1'b0;
        MemRW        = 1'b0;
        ILoad        = 3'b010;
        Addr         = 32'h0;
        WData        = 32'h0;
        bus_if.ack   = 1'b0;
        bus_if.err   = 1'b0;
        bus_if.rdata = 32'h0;

        // Reset values
        @(negedge clk);
        chk("rst_req",   32'(bus_if.req),   32'h0);
        chk("rst_we",    32'(bus_if.we),    32'h0);
        chk("rst_addr",  bus_if.addr,       32'h0);
        chk("rst_be",    32'(bus_if.be),    32'h0);
        chk("rst_wdata", bus_if.wdata,      32'h0);
        chk("rst_rdata", RData,             32'h0);
        chk("rst_fault", 32'(Fault),        32'h0);
        chk("rst_stall0", 32'(Stall_M),     32'h0);
        MemEn = 1'b1;
        #1;
        chk("rst_stall1", 32'(Stall_M),     32'h1);
        MemEn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // LW 0x100, zero-wait ack
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        chk("lw_be",     32'(cap_be),  32'hF);
        chk("lw_addr",   cap_addr,     32'h100);
        chk("lw_we",     32'(cap_we),  32'h0);
        chk("lw_stalls", 32'(stalls),  32'd2);
        chk("lw_rdata",  RData,        32'hDEADBEEF);
        chk("lw_fault",  32'(Fault),   32'h0);
        chk("lw_req_done", 32'(bus_if.req), 32'h0);
        finish_op();

        // LB 0x103, ack after 3 wait cycles
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 3, 32'h80123456, 1'b0);
        chk("lb_be",     32'(cap_be),  32'h8);
        chk("lb_stalls", 32'(stalls),  32'd5);
        chk("lb_rdata",  RData,        32'hFFFFFF80);
        finish_op();

        // LBU 0x103, same response
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 3, 32'h80123456, 1'b0);
        chk("lbu_rdata", RData,        32'h00000080);
        chk("lbu_stalls", 32'(stalls), 32'd5);
        finish_op();

        // LH 0x100 sign-extends; LHU 0x102 zero-extends upper half
        run_op(1'b0, 3'b001, 32'h100, 32'h0, 0, 32'h1234F00F, 1'b0);
        chk("lh_be",     32'(cap_be),  32'h3);
        chk("lh_rdata",  RData,        32'hFFFFF00F);
        finish_op();
        run_op(1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h9ABC1234, 1'b0);
        chk("lhu_be",    32'(cap_be),  32'hC);
        chk("lhu_rdata", RData,        32'h00009ABC);
        finish_op();

        // SH 0x202
        run_op(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 0, 32'h0, 1'b0);
        chk("sh_we",     32'(cap_we),  32'h1);
        chk("sh_be",     32'(cap_be),  32'hC);
        chk("sh_wdata",  cap_wdata,    32'hABCDABCD);
        chk("sh_addr",   cap_addr,     32'h200);
        chk("sh_fault",  32'(Fault),   32'h0);
        finish_op();

        // SB 0x301 replicates the byte
        run_op(1'b1, 3'b000, 32'h301, 32'h000000A5, 0, 32'h0, 1'b0);
        chk("sb_be",     32'(cap_be),  32'h2);
        chk("sb_wdata",  cap_wdata,    32'hA5A5A5A5);
        finish_op();

        // Bus error
        run_op(1'b0, 3'b010, 32'h500, 32'h0, 1, 32'h12345678, 1'b1);
        chk("err_fault", 32'(Fault),   32'h1);
        chk("err_rdata", RData,        32'h0);
        finish_op();

        // Timeout: no ack
        run_op(1'b0, 3'b010, 32'h600, 32'h0, -1, 32'h0, 1'b0);
        chk("to_reqs",   32'(reqs),    32'd16);
        chk("to_stalls", 32'(stalls),  32'd17);
        chk("to_fault",  32'(Fault),   32'h1);
        chk("to_rdata",  RData,        32'h0);
        // Late ack in IDLE must not start anything
        MemEn        = 1'b0;
        bus_if.ack   = 1'b1;
        bus_if.rdata = 32'h55555555;
        @(negedge clk);
        @(negedge clk);
        chk("late_req",   32'(bus_if.req), 32'h0);
        chk("late_stall", 32'(Stall_M),    32'h0);
        bus_if.ack   = 1'b0;
        @(negedge clk);

        // Misaligned word at 0x102
`ifdef DMEM_MISALIGN_TRAP_EN
        run_op(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h11223344, 1'b0);
        chk("mis_reqs",   32'(reqs),   32'd0);
        chk("mis_stalls", 32'(stalls), 32'd1);
        chk("mis_fault",  32'(Fault),  32'h1);
        chk("mis_rdata",  RData,       32'h0);
        finish_op();
`else
        run_op(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h11223344, 1'b0);
        chk("mis_be",     32'(cap_be), 32'hF);
        chk("mis_addr",   cap_addr,    32'h100);
        chk("mis_stalls", 32'(stalls), 32'd2);
        chk("mis_rdata",  RData,       32'h11223344);
        chk("mis_fault",  32'(Fault),  32'h0);
        finish_op();
`endif

        // Reset in the second ACCESS cycle drops req at once
        MemEn = 1'b1;
        MemRW = 1'b0;
        ILoad = 3'b010;
        Addr  = 32'h400;
        @(negedge clk);
        @(negedge clk);
        chk("mid_req_before", 32'(bus_if.req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_req_reset",  32'(bus_if.req), 32'h0);
        MemEn        = 1'b0;
        bus_if.ack   = 1'b1;
        bus_if.rdata = 32'hCAFEF00D;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_req_after",   32'(bus_if.req), 32'h0);
        chk("mid_stall_after", 32'(Stall_M),    32'h0);
        bus_if.ack = 1'b0;
        @(negedge clk);

        // Normal LW after reset recovery
        run_op(1'b0, 3'b010, 32'h700, 32'h0, 2, 32'h0BADF00D, 1'b0);
        chk("post_stalls", 32'(stalls), 32'd4);
        chk("post_rdata",  RData,       32'h0BADF00D);
        chk("post_fault",  32'(Fault),  32'h0);
        finish_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
